// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder controller.
//   DIGIT_W : width of one adder digit (bits processed per cycle)
//   state_e : controller FSM states
//   ndig()  : number of digits needed for a given operand width
package adder_pkg;

  localparam int unsigned DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned ndig(input int unsigned width);
    return width / DIGIT_W;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
//   in_valid/in_ready   : operand pair handshake (a, b)
//   out_valid/out_ready : result handshake (sum, WIDTH+1 bits)
//   busy                : controller is in RUN or DONE
// master = producer/consumer side, slave = controller side.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, busy
  );

endinterface

// File: rtl/adder_digit.sv
// Combinational single-digit adder slice.
//   a_i, b_i : DIGIT_W-bit operand digits
//   cin_i    : carry in
//   d_o      : DIGIT_W+1-bit result, MSB is carry out
module adder_digit
  import adder_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  input  logic               cin_i,
  output logic [DIGIT_W:0]   d_o
);

  always_comb begin
    d_o = {1'b0, a_i} + {1'b0, b_i} + {{DIGIT_W{1'b0}}, cin_i};
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Digit-serial add controller: adds two WIDTH-bit operands through one
// DIGIT_W-bit adder slice, least-significant digit first, carrying between
// digits, and returns a WIDTH+1-bit sum over a valid/ready handshake.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : serial_adder_ctrl_if slave (in_valid/in_ready/a/b,
//         out_valid/out_ready/sum, busy)
// WIDTH must be even and >= 2. Result appears NDIG edges after accept.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);

  localparam int unsigned NDIG   = ndig(WIDTH);
  localparam int unsigned DCNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e              state_q;
  logic [WIDTH-1:0]    a_sh_q;
  logic [WIDTH-1:0]    b_sh_q;
  logic                carry_q;
  logic [DCNT_W-1:0]   dcnt_q;
  logic [WIDTH:0]      sum_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;
  logic [DIGIT_W:0]    d;

  adder_digit u_digit (
    .a_i   (a_sh_q[DIGIT_W-1:0]),
    .b_i   (b_sh_q[DIGIT_W-1:0]),
    .cin_i (carry_q),
    .d_o   (d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      carry_q     <= 1'b0;
      dcnt_q      <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh_q     <= bus.a;
            b_sh_q     <= bus.b;
            carry_q    <= 1'b0;
            dcnt_q     <= '0;
            // Cleared so digits not yet produced read as zero during RUN.
            sum_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          // Constant-index write of the current digit keeps the sum
          // register a plain set of enabled flops.
          for (int unsigned i = 0; i < NDIG; i++) begin
            if (dcnt_q == DCNT_W'(i)) begin
              sum_q[i*DIGIT_W +: DIGIT_W] <= d[DIGIT_W-1:0];
            end
          end
          carry_q <= d[DIGIT_W];
          a_sh_q  <= a_sh_q >> DIGIT_W;
          b_sh_q  <= b_sh_q >> DIGIT_W;
          if (dcnt_q == DCNT_W'(NDIG - 1)) begin
            // Exit before the counter can wrap.
            sum_q[WIDTH] <= d[DIGIT_W];
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a_drv = '0;
  logic [15:0] b_drv = '0;

  int vec = 0;
  int miscomp = 0;
  int sel = 0;
  int acc_in = 0;
  int acc_out = 0;

  int widths [3] = '{8, 16, 2};

  logic [16:0] sum_m;
  logic        ov_m, ir_m, busy_m;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8))  if8  ();
  serial_adder_ctrl_if #(.WIDTH(16)) if16 ();
  serial_adder_ctrl_if #(.WIDTH(2))  if2  ();

  assign if8.in_valid   = in_valid;
  assign if8.out_ready  = out_ready;
  assign if8.a          = a_drv[7:0];
  assign if8.b          = b_drv[7:0];
  assign if16.in_valid  = in_valid;
  assign if16.out_ready = out_ready;
  assign if16.a         = a_drv;
  assign if16.b         = b_drv;
  assign if2.in_valid   = in_valid;
  assign if2.out_ready  = out_ready;
  assign if2.a          = a_drv[1:0];
  assign if2.b          = b_drv[1:0];

  serial_adder_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  serial_adder_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  serial_adder_ctrl #(.WIDTH(2))  dut2  (.clk(clk), .rst(rst), .bus(if2));

  always_comb begin
    sum_m = '0; ov_m = 1'b0; ir_m = 1'b0; busy_m = 1'b0;
    case (sel)
      0: begin sum_m = {8'b0, if8.sum};  ov_m = if8.out_valid;  ir_m = if8.in_ready;  busy_m = if8.busy;  end
      1: begin sum_m = if16.sum;         ov_m = if16.out_valid; ir_m = if16.in_ready; busy_m = if16.busy; end
      default: begin sum_m = {14'b0, if2.sum}; ov_m = if2.out_valid; ir_m = if2.in_ready; busy_m = if2.busy; end
    endcase
  end

  // Handshake monitor on the selected instance.
  always @(posedge clk) begin
    if (!rst) begin
      if (in_valid && ir_m)  acc_in++;
      if (out_ready && ov_m) acc_out++;
    end
  end

  // Reference: unsigned sum of the low w bits of each operand.
  function automatic logic [16:0] ref_sum(input int w, input logic [15:0] x, input logic [15:0] y);
    logic [16:0] m;
    m = (17'd1 << w) - 17'd1;
    return (({1'b0, x}) & m) + (({1'b0, y}) & m);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int s, output bit ok);
    int k;
    sel = s;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    k = 0;
    while (!ir_m && k < 40) begin
      tick();
      k++;
    end
    out_ready = 1'b0;
    ok = ir_m;
  endtask

  task automatic run_add(input int s, input logic [15:0] av, input logic [15:0] bv,
                         input int stall, input logic rdy_run,
                         output int lat, output logic [16:0] got,
                         output bit stable, output bit idle_ok);
    bit ok;
    drain(s, ok);
    lat = -1; got = '0; stable = 1'b0; idle_ok = 1'b0;
    if (!ok) return;
    in_valid = 1'b1;
    a_drv = av;
    b_drv = bv;
    out_ready = rdy_run;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!ov_m && lat < 64) begin
      tick();
      lat++;
    end
    if (!ov_m) lat = -1;
    got = sum_m;
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      tick();
      if (sum_m !== got || ov_m !== 1'b1 || ir_m !== 1'b0) stable = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    idle_ok = (ir_m === 1'b1) && (ov_m === 1'b0) && (busy_m === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      vec++;
      if (ir_m !== 1'b1 || ov_m !== 1'b0 || busy_m !== 1'b0 || sum_m !== 17'd0) begin
        miscomp++;
        $display("FAIL reset_state w=%0d: ir=%b ov=%b busy=%b sum=%h, want ir=1 ov=0 busy=0 sum=0",
                 widths[s], ir_m, ov_m, busy_m, sum_m);
      end
    end
  endtask

  task automatic test_carry_out();
    int lat; logic [16:0] got; bit st, idl;
    run_add(0, 16'h00FF, 16'h0001, 0, 1'b1, lat, got, st, idl);
    vec++;
    if (lat !== 4) begin miscomp++; $display("FAIL carry_out_latency: got %0d want 4", lat); end
    vec++;
    if (got !== ref_sum(8, 16'h00FF, 16'h0001)) begin miscomp++; $display("FAIL carry_out_sum: got %h want %h", got, 17'h100); end
    vec++;
    if (!idl) begin miscomp++; $display("FAIL carry_out_idle: ir=%b ov=%b busy=%b want 1 0 0", ir_m, ov_m, busy_m); end
  endtask

  task automatic test_no_carry();
    bit ok; int k;
    drain(0, ok);
    in_valid = 1'b1; a_drv = 16'h00A5; b_drv = 16'h005A;
    tick();
    in_valid = 1'b0;
    vec++;
    if (sum_m !== 17'd0 || busy_m !== 1'b1 || ir_m !== 1'b0) begin
      miscomp++; $display("FAIL no_carry_accept: sum=%h busy=%b ir=%b want 0 1 0", sum_m, busy_m, ir_m);
    end
    k = 0;
    while (!ov_m && k < 20) begin
      tick();
      k++;
      vec++;
      if (dut8.carry_q !== 1'b0) begin miscomp++; $display("FAIL no_carry_carryreg: got %b want 0", dut8.carry_q); end
    end
    vec++;
    if (k !== 4 || sum_m !== ref_sum(8, 16'h00A5, 16'h005A)) begin
      miscomp++; $display("FAIL no_carry_sum: lat=%0d sum=%h want lat=4 sum=0ff", k, sum_m);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_hold();
    bit ok; int k; bit held;
    drain(0, ok);
    in_valid = 1'b1; a_drv = 16'h00FF; b_drv = 16'h00FF;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!ov_m && k < 20) begin tick(); k++; end
    vec++;
    if (k !== 4 || ov_m !== 1'b1) begin miscomp++; $display("FAIL hold_latency: got %0d want 4", k); end
    held = 1'b1;
    for (int i = 0; i < 6; i++) begin
      out_ready = 1'b0; in_valid = 1'b1; a_drv = 16'h0012; b_drv = 16'h0034;
      tick();
      if (ov_m !== 1'b1 || ir_m !== 1'b0 || sum_m !== ref_sum(8, 16'h00FF, 16'h00FF)) held = 1'b0;
    end
    vec++;
    if (!held) begin miscomp++; $display("FAIL hold_stable: ov=%b ir=%b sum=%h want 1 0 1fe", ov_m, ir_m, sum_m); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vec++;
    if (ir_m !== 1'b1 || ov_m !== 1'b0) begin miscomp++; $display("FAIL hold_release: ir=%b ov=%b want 1 0", ir_m, ov_m); end
    held = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ov_m !== 1'b0 || busy_m !== 1'b0) held = 1'b0;
    end
    vec++;
    if (!held) begin miscomp++; $display("FAIL hold_ignored_pair: ov=%b busy=%b want 0 0", ov_m, busy_m); end
  endtask

  task automatic test_reset_mid();
    bit ok; bit quiet; int lat; logic [16:0] got; bit st, idl;
    drain(0, ok);
    in_valid = 1'b1; a_drv = 16'h000F; b_drv = 16'h0001;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec++;
    if (ir_m !== 1'b1 || ov_m !== 1'b0 || sum_m !== 17'd0 || busy_m !== 1'b0) begin
      miscomp++; $display("FAIL reset_mid_state: ir=%b ov=%b sum=%h busy=%b want 1 0 0 0", ir_m, ov_m, sum_m, busy_m);
    end
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ov_m !== 1'b0) quiet = 1'b0;
    end
    vec++;
    if (!quiet) begin miscomp++; $display("FAIL reset_mid_no_pulse: out_valid=1 want 0"); end
    run_add(0, 16'h0003, 16'h0004, 0, 1'b1, lat, got, st, idl);
    vec++;
    if (lat !== 4 || got !== 17'h007) begin miscomp++; $display("FAIL reset_mid_fresh: lat=%0d sum=%h want 4 007", lat, got); end
  endtask

  task automatic test_width2();
    int lat; logic [16:0] got; bit st, idl;
    rst = 1'b1; tick(); rst = 1'b0;
    run_add(2, 16'h0003, 16'h0003, 2, 1'b0, lat, got, st, idl);
    vec++;
    if (lat !== 1) begin miscomp++; $display("FAIL w2_latency: got %0d want 1", lat); end
    vec++;
    if (got !== ref_sum(2, 16'h0003, 16'h0003)) begin miscomp++; $display("FAIL w2_sum: got %h want 6", got); end
    vec++;
    if (!st || !idl) begin miscomp++; $display("FAIL w2_handshake: stable=%b idle=%b want 1 1", st, idl); end
  endtask

  task automatic test_random_sweep(input int s);
    int lat; logic [16:0] got; bit st, idl;
    logic [15:0] av, bv; int stall; logic rdy;
    int w;
    w = widths[s];
    sel = s;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    acc_in = 0; acc_out = 0;
    for (int n = 0; n < 1000; n++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      stall = int'($urandom_range(0, 3));
      rdy = 1'($urandom_range(0, 1));
      run_add(s, av, bv, stall, rdy, lat, got, st, idl);
      vec++;
      if (lat !== w / 2) begin miscomp++; $display("FAIL sweep_latency w=%0d n=%0d: got %0d want %0d", w, n, lat, w / 2); end
      vec++;
      if (got !== ref_sum(w, av, bv)) begin
        miscomp++; $display("FAIL sweep_sum w=%0d a=%h b=%h: got %h want %h", w, av, bv, got, ref_sum(w, av, bv));
      end
      vec++;
      if (!st || !idl) begin miscomp++; $display("FAIL sweep_handshake w=%0d n=%0d: stable=%b idle=%b want 1 1", w, n, st, idl); end
    end
    tick();
    vec++;
    if (acc_in !== 1000 || acc_out !== 1000) begin
      miscomp++; $display("FAIL sweep_counts w=%0d: in=%0d out=%0d want 1000 1000", w, acc_in, acc_out);
    end
  endtask

  initial begin
    test_reset();
    test_carry_out();
    test_no_carry();
    test_hold();
    test_reset_mid();
    test_width2();
    test_random_sweep(0);
    test_random_sweep(1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Digit-serial add controller. It reuses a single 2-bit adder slice over multiple cycles to add two WIDTH-bit operands.
- It sequences the slice least-significant digit first and holds the carry between digits.
- It presents a WIDTH+1-bit sum through a valid/ready handshake.
- It sits in front of wide adders where area matters more than latency, and replaces the parallel multi-slice add.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 2.
- NDIG, WIDTH/2, number of 2-bit digits (derived; not overridable).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  controller can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  sum available.
- out_ready  input  1  consumer accepts sum.
- sum  output  WIDTH+1  A+B, MSB is the final carry.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high. rst sampled high at an edge forces IDLE, clears the operand shifters, the carry, the digit counter and the sum register. Resulting values: in_ready=1, out_valid=0, busy=0, sum=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On edge with in_valid=1, latch a and b into shift registers, clear carry=0 and dcnt=0, go to RUN. With in_valid=0, stay in IDLE.
- RUN: in_ready=0. Each edge computes d = a_sh[1:0] + b_sh[1:0] + carry, a 3-bit result.
  - d[1:0] goes into sum digit dcnt; carry <= d[2].
  - a_sh and b_sh shift right by 2; dcnt increments.
  - On the edge where dcnt==NDIG-1, write sum[WIDTH] = the d[2] of that edge and go to DONE.
- DONE: out_valid=1. sum is stable and unchanged while out_valid=1 && out_ready=0. On an edge with out_ready=1, go to IDLE and drop out_valid. in_valid is ignored in DONE; no back-to-back overlap.
- Latency: out_valid rises exactly NDIG edges after the accepting edge; throughput is one add per NDIG+2 cycles minimum.
- Width rules: all digit arithmetic is unsigned, with no truncation of the carry. Sum digits not yet written in RUN read as 0, because the sum register clears on accept.
- WIDTH=2 (NDIG=1): RUN lasts exactly one edge.
- Counter: dcnt width is $clog2(NDIG), minimum 1 bit. It never wraps inside an operation because the exit happens at NDIG-1.
- Reset mid-operation: any state returns to IDLE on the next edge and the in-flight result is discarded. out_valid never pulses for an aborted add.
- Reset priority: rst has priority over in_valid and over out_ready in the same cycle.
- Unknown-value safety: in_valid outside IDLE and out_ready outside DONE have no effect.

Decomposition:
- Shared package adder_pkg:
  - DIGIT_W=2 constant.
  - State enum {IDLE, RUN, DONE}.
  - Function ndig(width) returning width/DIGIT_W.
- One sub-module, adder_digit: combinational 2-bit + 2-bit + carry-in → 3-bit result. It is instantiated once in serial_adder_ctrl.
- The FSM, shifters and counter stay in the top module.

Test Plan:
- WIDTH=8, a=8'hFF, b=8'h01, out_ready=1 → out_valid rises 4 edges after accept; sum=9'h100; FSM back in IDLE one edge later.
- WIDTH=8, a=8'hA5, b=8'h5A → sum=9'h0FF, with no carry into bit 8. Also check the per-digit carry register stays 0.
- WIDTH=8, a=8'hFF, b=8'hFF, out_ready held 0 for 6 cycles → sum=9'h1FE held stable with out_valid=1 throughout. Meanwhile in_valid=1 with a new pair is ignored. Released on out_ready=1.
- rst asserted on the 2nd RUN edge of a=8'h0F, b=8'h01 → next cycle in_ready=1, out_valid=0, sum=0. A fresh add of 8'h03+8'h04 then yields 9'h007.
- WIDTH=2 build, a=2'b11, b=2'b11 → out_valid 1 edge after accept, sum=3'b110.
- Random sweep of 1000 pairs at WIDTH=8 and WIDTH=16, with random out_ready stalls → every sum equals a+b, and exactly one out_valid acceptance per in_valid acceptance.
